// File: rtl/pfw_pkg.sv
// Shared types and elaboration helpers for the pixel frame writer.
package pfw_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } pfw_state_t;

    function automatic int unsigned frame_pixels(input int unsigned img_width,
                                                 input int unsigned img_height);
        return img_width * img_height;
    endfunction

    // Index width of a RAM holding depth words; at least one bit.
    function automatic int unsigned ram_index_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit addr_width_ok(input int unsigned addr_width,
                                         input int unsigned pixels);
        if (addr_width >= 32) begin
            return 1'b1;
        end
        return (64'(1) << addr_width) >= 64'(pixels);
    endfunction

endpackage

// File: rtl/pfw_frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read-first read port.
module pfw_frame_ram
    import pfw_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 76080,
    parameter int unsigned ADDR_WIDTH = 20
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [ram_index_width(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic                                rd_en,
    input  logic [ADDR_WIDTH-1:0]               rd_addr,
    output logic [DATA_WIDTH-1:0]               rd_data,
    output logic                                rd_valid
);

    localparam int unsigned IDX_WIDTH = ram_index_width(DEPTH);
    localparam int unsigned EXT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [EXT_WIDTH-1:0] DEPTH_EXT = EXT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  rd_in_range_c;

    // Extra top bit keeps the compare exact even when DEPTH == 2**ADDR_WIDTH.
    assign rd_in_range_c = {1'b0, rd_addr} < DEPTH_EXT;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Array read sees the pre-edge contents, so a same-address write returns old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_in_range_c ? mem[rd_addr[IDX_WIDTH-1:0]] : '0;
            end
        end
    end

endmodule

// File: rtl/pixel_frame_writer.sv
// Raster pixel stream sink: captures one frame into the frame RAM and
// exposes it through a registered random-access read port.
module pixel_frame_writer
    import pfw_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 317,
    parameter int unsigned IMG_HEIGHT = 240,
    parameter int unsigned ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [9:0]            col,
    output logic [9:0]            row,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_ready,
    output logic                  overflow
);

    localparam int unsigned FRAME_PIXELS  = frame_pixels(IMG_WIDTH, IMG_HEIGHT);
    localparam int unsigned RAM_IDX_WIDTH = ram_index_width(FRAME_PIXELS);
    localparam int unsigned CNT_WIDTH     = 10;
    localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMG_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMG_HEIGHT - 1);

    if (!addr_width_ok(ADDR_WIDTH, FRAME_PIXELS)) begin : g_addr_width_check
        $error("pixel_frame_writer: ADDR_WIDTH too small for IMG_WIDTH*IMG_HEIGHT");
    end

    pfw_state_t state;
    logic       wr_en_c;
    logic       last_pixel_c;

    // A start in the same cycle wins over the pixel, so it is never written.
    assign wr_en_c      = (state == CAPTURE) && data_valid && !start;
    assign last_pixel_c = (col == COL_LAST) && (row == ROW_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_addr     <= '0;
            col         <= '0;
            row         <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_ready <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (start) begin
                // Entry or restart; a pixel arriving with start counts as overflow.
                state       <= CAPTURE;
                wr_addr     <= '0;
                col         <= '0;
                row         <= '0;
                busy        <= 1'b1;
                frame_ready <= 1'b0;
                overflow    <= data_valid;
            end else begin
                case (state)
                    CAPTURE: begin
                        if (data_valid) begin
                            wr_addr <= wr_addr + ADDR_WIDTH'(1);
                            if (col == COL_LAST) begin
                                col <= '0;
                                row <= row + CNT_WIDTH'(1);
                            end else begin
                                col <= col + CNT_WIDTH'(1);
                            end
                            if (last_pixel_c) begin
                                state       <= DONE;
                                busy        <= 1'b0;
                                frame_done  <= 1'b1;
                                frame_ready <= 1'b1;
                            end
                        end
                    end
                    IDLE, DONE: begin
                        if (data_valid) begin
                            overflow <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    pfw_frame_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FRAME_PIXELS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en_c),
        .wr_addr  (wr_addr[RAM_IDX_WIDTH-1:0]),
        .wr_data  (data_in),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Self-checking bench for pixel_frame_writer on a 4x3 frame against a pixel-count model.
module tb_pixel_frame_writer;

    localparam int unsigned DW = 8;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned AW = 20;
    localparam int unsigned FP = W * H;

    logic          clk;
    logic          rst;
    logic          start;
    logic          data_valid;
    logic [DW-1:0] data_in;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] wr_addr;
    logic [9:0]    col;
    logic [9:0]    row;
    logic          busy;
    logic          frame_done;
    logic          frame_ready;
    logic          overflow;

    pixel_frame_writer #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .wr_addr     (wr_addr),
        .col         (col),
        .row         (row),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_ready (frame_ready),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: a pixel count plus a sparse image store.
    logic [7:0] m_ram [int];
    bit         m_cap;
    bit         m_done;
    bit         m_pulse;
    bit         m_ovf;
    int         m_n;
    logic       m_rd_valid;
    logic [7:0] m_rd_data;

    function automatic void model_reset();
        m_cap      = 1'b0;
        m_done     = 1'b0;
        m_pulse    = 1'b0;
        m_ovf      = 1'b0;
        m_n        = 0;
        m_rd_valid = 1'b0;
        m_rd_data  = 8'h00;
    endfunction

    function automatic logic [43:0] exp_status();
        return {m_cap, m_done, m_pulse, m_ovf, 20'(m_n), 10'(m_n % W), 10'(m_n / W)};
    endfunction

    function automatic logic [43:0] dut_status();
        return {busy, frame_ready, frame_done, overflow, wr_addr, col, row};
    endfunction

    // One clock with the given inputs; model advanced from the rules of the frame.
    task automatic cycle(input bit st, input bit dv, input logic [7:0] d,
                         input bit re, input logic [AW-1:0] ra);
        start      = st;
        data_valid = dv;
        data_in    = d;
        rd_en      = re;
        rd_addr    = ra;
        @(posedge clk);
        #1;
        start      = 1'b0;
        data_valid = 1'b0;
        rd_en      = 1'b0;
        m_pulse    = 1'b0;
        if (re) begin
            m_rd_valid = 1'b1;
            m_rd_data  = (ra < AW'(FP)) ? m_ram[int'(ra)] : 8'h00;
        end else begin
            m_rd_valid = 1'b0;
        end
        if (st) begin
            m_cap  = 1'b1;
            m_done = 1'b0;
            m_n    = 0;
            m_ovf  = dv;
        end else if (dv) begin
            if (m_cap) begin
                m_ram[m_n] = d;
                m_n++;
                if (m_n == FP) begin
                    m_cap   = 1'b0;
                    m_done  = 1'b1;
                    m_pulse = 1'b1;
                end
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if (dut_status() !== exp_status()) begin
            tests_failed++;
            $display("FAIL reset_status: got %h expected %h", dut_status(), exp_status());
        end
        tests_run++;
        if ({rd_valid, rd_data} !== 9'h000) begin
            tests_failed++;
            $display("FAIL reset_read: got %h expected 000", {rd_valid, rd_data});
        end
    endtask

    task automatic test_idle_overflow();
        cycle(1'b0, 1'b1, 8'hFF, 1'b0, '0);
        tests_run++;
        if (dut_status() !== exp_status()) begin
            tests_failed++;
            $display("FAIL idle_overflow: got %h expected %h", dut_status(), exp_status());
        end
    endtask

    task automatic test_frame_b2b();
        int pulses = 0;
        cycle(1'b1, 1'b0, 8'h00, 1'b0, '0);
        tests_run++;
        if (dut_status() !== exp_status()) begin
            tests_failed++;
            $display("FAIL b2b_start: got %h expected %h", dut_status(), exp_status());
        end
        for (int i = 0; i <= int'(FP); i++) begin
            cycle(1'b0, i < int'(FP), 8'(i), 1'b0, '0);
            if (frame_done) pulses++;
            tests_run++;
            if (dut_status() !== exp_status() || rd_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_pixel%0d: got %h/%b expected %h/0", i, dut_status(),
                         rd_valid, exp_status());
            end
        end
        tests_run++;
        if (pulses !== 1) begin
            tests_failed++;
            $display("FAIL b2b_done_pulses: got %0d expected 1", pulses);
        end
        for (int a = 0; a <= int'(FP); a++) begin
            cycle(1'b0, 1'b0, 8'h00, a < int'(FP), AW'(a));
            tests_run++;
            if ({rd_valid, rd_data} !== {m_rd_valid, m_rd_data}) begin
                tests_failed++;
                $display("FAIL b2b_read%0d: got %b/%h expected %b/%h", a, rd_valid, rd_data,
                         m_rd_valid, m_rd_data);
            end
        end
    endtask

    task automatic test_done_overflow();
        cycle(1'b0, 1'b1, 8'hFF, 1'b0, '0);
        tests_run++;
        if (dut_status() !== exp_status()) begin
            tests_failed++;
            $display("FAIL done_overflow: got %h expected %h", dut_status(), exp_status());
        end
        for (int a = 0; a < int'(FP); a++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, AW'(a));
            tests_run++;
            if ({rd_valid, rd_data} !== {m_rd_valid, m_rd_data}) begin
                tests_failed++;
                $display("FAIL done_read%0d: got %b/%h expected %b/%h", a, rd_valid, rd_data,
                         m_rd_valid, m_rd_data);
            end
        end
    endtask

    task automatic test_frame_gaps(input bit rand_data, input string tag);
        logic [7:0] d;
        cycle(1'b1, 1'b0, 8'h00, 1'b0, '0);
        for (int i = 0; i < int'(FP); i++) begin
            repeat ($urandom_range(0, 5)) begin
                cycle(1'b0, 1'b0, 8'h00, 1'b0, '0);
                tests_run++;
                if (dut_status() !== exp_status()) begin
                    tests_failed++;
                    $display("FAIL %s_gap%0d: got %h expected %h", tag, i, dut_status(),
                             exp_status());
                end
            end
            d = rand_data ? 8'($urandom) : 8'(i);
            cycle(1'b0, 1'b1, d, 1'b0, '0);
            tests_run++;
            if (dut_status() !== exp_status()) begin
                tests_failed++;
                $display("FAIL %s_pixel%0d: got %h expected %h", tag, i, dut_status(),
                         exp_status());
            end
        end
        for (int a = 0; a < int'(FP); a++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, AW'(a));
            tests_run++;
            if ({rd_valid, rd_data} !== {m_rd_valid, m_rd_data}) begin
                tests_failed++;
                $display("FAIL %s_read%0d: got %b/%h expected %b/%h", tag, a, rd_valid,
                         rd_data, m_rd_valid, m_rd_data);
            end
        end
    endtask

    task automatic test_read_edges();
        cycle(1'b0, 1'b0, 8'h00, 1'b1, AW'(FP));
        tests_run++;
        if ({rd_valid, rd_data} !== 9'h100) begin
            tests_failed++;
            $display("FAIL read_addr_frame: got %b/%h expected 1/00", rd_valid, rd_data);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 20'hFFFFF);
        tests_run++;
        if ({rd_valid, rd_data} !== 9'h100) begin
            tests_failed++;
            $display("FAIL read_addr_max: got %b/%h expected 1/00", rd_valid, rd_data);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, '0);
        tests_run++;
        if ({rd_valid, rd_data} !== 9'h000) begin
            tests_failed++;
            $display("FAIL read_idle_hold: got %b/%h expected 0/00", rd_valid, rd_data);
        end
        cycle(1'b1, 1'b0, 8'h00, 1'b0, '0);
        cycle(1'b0, 1'b1, 8'h51, 1'b0, '0);
        cycle(1'b0, 1'b1, 8'h52, 1'b0, '0);
        cycle(1'b0, 1'b1, 8'h53, 1'b1, AW'(2));
        tests_run++;
        if ({rd_valid, rd_data} !== {m_rd_valid, m_rd_data}) begin
            tests_failed++;
            $display("FAIL read_first_old: got %b/%h expected %b/%h", rd_valid, rd_data,
                     m_rd_valid, m_rd_data);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, AW'(2));
        tests_run++;
        if ({rd_valid, rd_data} !== 9'h153) begin
            tests_failed++;
            $display("FAIL read_after_write: got %b/%h expected 1/53", rd_valid, rd_data);
        end
        for (int i = 3; i < int'(FP); i++) begin
            cycle(1'b0, 1'b1, 8'(8'h60 + i), 1'b0, '0);
            tests_run++;
            if (dut_status() !== exp_status()) begin
                tests_failed++;
                $display("FAIL read_fill%0d: got %h expected %h", i, dut_status(),
                         exp_status());
            end
        end
    endtask

    task automatic test_restart();
        int pulses = 0;
        cycle(1'b1, 1'b0, 8'h00, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 8'($urandom), 1'b0, '0);
        end
        tests_run++;
        if (dut_status() !== exp_status()) begin
            tests_failed++;
            $display("FAIL restart_partial: got %h expected %h", dut_status(), exp_status());
        end
        cycle(1'b1, 1'b0, 8'h00, 1'b0, '0);
        tests_run++;
        if (dut_status() !== exp_status()) begin
            tests_failed++;
            $display("FAIL restart_clear: got %h expected %h", dut_status(), exp_status());
        end
        for (int i = 0; i <= int'(FP); i++) begin
            cycle(1'b0, i < int'(FP), 8'(8'hA0 + i), 1'b0, '0);
            if (frame_done) pulses++;
        end
        tests_run++;
        if (pulses !== 1) begin
            tests_failed++;
            $display("FAIL restart_done_pulses: got %0d expected 1", pulses);
        end
        for (int a = 0; a < int'(FP); a++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, AW'(a));
            tests_run++;
            if ({rd_valid, rd_data} !== {1'b1, 8'(8'hA0 + a)}) begin
                tests_failed++;
                $display("FAIL restart_read%0d: got %b/%h expected 1/%h", a, rd_valid,
                         rd_data, 8'(8'hA0 + a));
            end
        end
    endtask

    task automatic test_rst_midframe();
        cycle(1'b1, 1'b1, 8'hEE, 1'b0, '0);
        tests_run++;
        if (dut_status() !== exp_status()) begin
            tests_failed++;
            $display("FAIL start_with_valid: got %h expected %h", dut_status(), exp_status());
        end
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b1, 8'(8'h30 + i), i == 6, AW'(1));
        end
        tests_run++;
        if (dut_status() !== exp_status() || {rd_valid, rd_data} !== {m_rd_valid, m_rd_data}) begin
            tests_failed++;
            $display("FAIL pre_rst_state: got %h/%b/%h expected %h/%b/%h", dut_status(),
                     rd_valid, rd_data, exp_status(), m_rd_valid, m_rd_data);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({dut_status(), rd_valid, rd_data} !== 53'h0) begin
            tests_failed++;
            $display("FAIL async_rst_outputs: got %h/%b/%h expected all zero", dut_status(),
                     rd_valid, rd_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b1, 8'hFF, 1'b0, '0);
        tests_run++;
        if (dut_status() !== exp_status()) begin
            tests_failed++;
            $display("FAIL post_rst_no_capture: got %h expected %h", dut_status(),
                     exp_status());
        end
        cycle(1'b1, 1'b0, 8'h00, 1'b0, '0);
        tests_run++;
        if (dut_status() !== exp_status()) begin
            tests_failed++;
            $display("FAIL post_rst_start: got %h expected %h", dut_status(), exp_status());
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, '0);
        tests_run++;
        if (rd_valid !== 1'b1 || rd_data === 8'hFF) begin
            tests_failed++;
            $display("FAIL idle_pixel_not_written: got %b/%h expected 1/not ff", rd_valid,
                     rd_data);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_idle_overflow();
        test_frame_b2b();
        test_done_overflow();
        test_frame_gaps(1'b0, "gaps");
        test_frame_gaps(1'b1, "random");
        test_read_edges();
        test_restart();
        test_rst_midframe();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
